// File: rtl/pipe_rx.sv
// Result collector for a credit-managed arithmetic pipeline: in-flight credit accounting plus result FIFO.
// Latency: in_valid to out_valid is 1 clk, with no bypass. Backpressure: out_ready stalls the head, and issue_ok withholds credit once occupancy+inflight reaches DEPTH.
// Overflow: a result that arrives while the FIFO is full and not popping is dropped and flagged.
module pipe_rx #(
    parameter int N     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue,
    output logic                     issue_ok,
    input  logic                     in_valid,
    input  logic [N-1:0]             in_data,
    output logic                     out_valid,
    output logic [N-1:0]             out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              rx_total,
    output logic                     err_ovf,
    output logic                     err_unexp,
    output logic                     err_issue
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW:0]   LIM    = (CW+1)'(DEPTH);

    logic [CW-1:0] occ;
    logic [CW-1:0] infl;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [N-1:0]  mem [DEPTH];

    logic [CW:0] credit_used;
    logic        issue_acc;
    logic        ret;
    logic        push;
    logic        pop;
    logic        full;

    // Credit is derived from registered state only, so issue_ok never depends on this cycle's inputs.
    assign credit_used = {1'b0, occ} + {1'b0, infl};
    assign issue_ok    = (credit_used < LIM);
    assign issue_acc   = issue & issue_ok;
    assign ret         = in_valid & (infl != '0);

    assign full      = (occ == FULL_C);
    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);

    assign out_data  = mem[rd_ptr];
    assign count     = occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= '0;
            infl      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_total  <= '0;
            err_ovf   <= 1'b0;
            err_unexp <= 1'b0;
            err_issue <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                rx_total <= rx_total + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase

            case ({issue_acc, ret})
                2'b10:   infl <= infl + CW'(1);
                2'b01:   infl <= infl - CW'(1);
                default: infl <= infl;
            endcase

            if (in_valid && full && !pop) begin
                err_ovf <= 1'b1;
            end
            if (in_valid && (infl == '0)) begin
                err_unexp <= 1'b1;
            end
            if (issue && !issue_ok) begin
                err_issue <= 1'b1;
            end
        end
    end

    // Storage is intentionally unreset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_rx.sv
// Directed bench for pipe_rx at N=10, DEPTH=4: credit limit, ordering, full boundary, async reset, pointer wrap.
module tb_pipe_rx;

    localparam int N     = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          issue = 1'b0;
    logic          issue_ok;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [2:0]    count;
    logic [15:0]   rx_total;
    logic          err_ovf;
    logic          err_unexp;
    logic          err_issue;

    int n_cmp = 0;
    int n_err = 0;

    pipe_rx #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .rx_total  (rx_total),
        .err_ovf   (err_ovf),
        .err_unexp (err_unexp),
        .err_issue (err_issue)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"},     32'(count),     32'd0);
        check({tag, "_issue_ok"},  32'(issue_ok),  32'd1);
        check({tag, "_rx_total"},  32'(rx_total),  32'd0);
        check({tag, "_errs"},      32'({err_ovf, err_unexp, err_issue}), 32'd0);
    endtask

    initial begin
        logic [N-1:0] exp_q [4];

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset0");
        tick();
        rst_n = 1'b1;
        tick();

        // Single result: issue, result 3 cycles later, visible 1 clk after
        issue = 1'b1;
        tick();
        issue = 1'b0;
        check("single_issue_ok_after_issue", 32'(issue_ok), 32'd1);
        tick();
        tick();
        in_valid = 1'b1; in_data = 10'd13;
        check("single_no_bypass", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data",  32'(out_data),  32'd13);
        check("single_rx_total",  32'(rx_total),  32'd1);
        check("single_no_unexp",  32'(err_unexp), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drained", 32'(out_valid), 32'd0);

        // Ordering and backpressure
        issue = 1'b1;
        tick();
        tick();
        issue = 1'b0;
        in_valid = 1'b1; in_data = 10'd13;
        tick();
        in_data = 10'd11;
        tick();
        in_valid = 1'b0;
        check("order_count2",    32'(count),    32'd2);
        check("order_head",      32'(out_data), 32'd13);
        tick();
        check("order_head_hold", 32'(out_data), 32'd13);
        out_ready = 1'b1;
        tick();
        check("order_second",    32'(out_data), 32'd11);
        check("order_count1",    32'(count),    32'd1);
        tick();
        out_ready = 1'b0;
        check("order_empty",     32'(out_valid), 32'd0);
        check("order_rx_total",  32'(rx_total),  32'd3);

        // Credit limit: four issues exhaust credit, a fifth is rejected
        issue = 1'b1;
        tick(); tick(); tick();
        check("credit_after3", 32'(issue_ok), 32'd1);
        tick();
        check("credit_after4", 32'(issue_ok), 32'd0);
        check("credit_no_err", 32'(err_issue), 32'd0);
        tick();
        issue = 1'b0;
        check("credit_err_issue", 32'(err_issue), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = N'(i);
            tick();
        end
        in_valid = 1'b0;
        check("credit_count4",    32'(count),     32'd4);
        check("credit_no_ovf",    32'(err_ovf),   32'd0);
        check("credit_no_unexp",  32'(err_unexp), 32'd0);
        check("credit_issue_ok0", 32'(issue_ok),  32'd0);

        // Full boundary: push with pop keeps count, push without pop drops
        in_valid = 1'b1; in_data = 10'd5; out_ready = 1'b1;
        tick();
        check("full_pushpop_count", 32'(count),     32'd4);
        check("full_pushpop_head",  32'(out_data),  32'd2);
        check("full_stray_unexp",   32'(err_unexp), 32'd1);
        check("full_pushpop_ovf",   32'(err_ovf),   32'd0);
        in_data = 10'd6; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("full_drop_ovf",      32'(err_ovf),  32'd1);
        check("full_drop_count",    32'(count),    32'd4);
        check("full_drop_rx_total", 32'(rx_total), 32'd8);
        exp_q[0] = 10'd2; exp_q[1] = 10'd3; exp_q[2] = 10'd4; exp_q[3] = 10'd5;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_drain_%0d", i), 32'(out_data), 32'(exp_q[i]));
            tick();
        end
        out_ready = 1'b0;
        check("full_drained", 32'(out_valid), 32'd0);

        // Mid-stream reset clears everything without a clock edge
        issue = 1'b1;
        tick();
        tick();
        issue = 1'b0;
        in_valid = 1'b1; in_data = 10'd9;
        tick();
        in_valid = 1'b0;
        check("mid_pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        issue = 1'b1; in_valid = 1'b1;
        tick();
        check_reset_outputs("midreset_held");
        issue = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Stray result after reset: flagged as unexpected but still stored
        in_valid = 1'b1; in_data = 10'd7;
        tick();
        in_valid = 1'b0;
        check("stray_unexp",    32'(err_unexp), 32'd1);
        check("stray_stored",   32'(out_data),  32'd7);
        check("stray_count",    32'(count),     32'd1);
        check("stray_rx_total", 32'(rx_total),  32'd1);

        // Wrap-around: fresh reset then 20 streaming push/pop pairs
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = N'(100 + i);
            tick();
            check($sformatf("wrap_data_%0d", i), 32'(out_data), 32'(100 + i));
        end
        in_valid = 1'b0;
        check("wrap_count", 32'(count), 32'd1);
        tick();
        out_ready = 1'b0;
        check("wrap_empty",    32'(out_valid), 32'd0);
        check("wrap_rx_total", 32'(rx_total),  32'd20);
        check("wrap_no_ovf",   32'(err_ovf),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
